// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch/jump/halt flush arbitration and halt drain
// Optional perf counters (StallCnt/FlushCnt) are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES = 3
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UsesRt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rt,
    input  logic       Branch,
    input  logic       Jump,
    input  logic       Halt,
    output logic       PCWre,
    output logic       IF_ID_Wre,
    output logic       ControlSrc,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       EX_MEM_Flush,
    output logic       Halted
`ifdef HAZARD_PERF_CNT_EN
    , output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);
    typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;

    localparam logic [3:0] STALL_LAST = 4'(STALL_CYCLES - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       lu;

    assign lu = EX_MemRead && EX_rt != 5'd0 &&
                (EX_rt == ID_rs || (ID_UsesRt && EX_rt == ID_rt));

    // Next state and outputs; a taken branch overrides every action except a completed halt
    always_comb begin
        PCWre        = 1'b1;
        IF_ID_Wre    = 1'b1;
        ControlSrc   = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        Halted       = 1'b0;
        state_n      = state;
        cnt_n        = cnt;
        if (Branch && state != HALTED) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            state_n      = RUN;
            cnt_n        = 4'd0;
        end else begin
            case (state)
                RUN, STALL: begin
                    if (state == STALL || lu) begin
                        PCWre      = 1'b0;
                        IF_ID_Wre  = 1'b0;
                        ControlSrc = 1'b1;
                        if (state == STALL) begin
                            state_n = (cnt == STALL_LAST) ? RUN : STALL;
                            cnt_n   = (cnt == STALL_LAST) ? 4'd0 : cnt + 4'd1;
                        end else if (STALL_CYCLES > 1) begin
                            state_n = STALL;
                            cnt_n   = 4'd1;
                        end
                    end else if (Jump) begin
                        IF_ID_Flush = 1'b1;
                    end else if (Halt) begin
                        PCWre       = 1'b0;
                        IF_ID_Flush = 1'b1;
                        state_n     = DRAIN;
                        cnt_n       = 4'd0;
                    end
                end
                DRAIN: begin
                    PCWre       = 1'b0;
                    IF_ID_Flush = 1'b1;
                    state_n     = (cnt == DRAIN_LAST) ? HALTED : DRAIN;
                    cnt_n       = (cnt == DRAIN_LAST) ? 4'd0 : cnt + 4'd1;
                end
                default: begin
                    PCWre     = 1'b0;
                    IF_ID_Wre = 1'b0;
                    Halted    = 1'b1;
                end
            endcase
        end
        if (!Reset) begin
            PCWre        = 1'b0;
            IF_ID_Wre    = 1'b0;
            ControlSrc   = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            Halted       = 1'b0;
        end
    end

    // State and sequencing counter register
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic flush_evt;

    assign flush_evt = state != HALTED && (Branch || (state == RUN && !lu && Jump));

    // Bubble and branch/jump flush counters, frozen once halted
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else if (state != HALTED) begin
            StallCnt <= StallCnt + CNT_W'(ControlSrc);
            FlushCnt <= FlushCnt + CNT_W'(flush_evt);
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for two hazard controllers (1 and 3 bubbles per load-use)
module tb_pipeline_hazard_ctrl;
    localparam int DRAIN = 3;

    typedef struct {
        logic [6:0]  o;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic       CLK = 1'b0, Reset = 1'b0;
    logic [4:0] ID_rs = 0, ID_rt = 0, EX_rt = 0;
    logic       ID_UsesRt = 0, EX_MemRead = 0, Branch = 0, Jump = 0, Halt = 0;
    wire  [6:0] o0, o1;
`ifdef HAZARD_PERF_CNT_EN
    wire [31:0] sc0, fc0, sc1, fc1;
`endif

    int    checks = 0, failures = 0, cycle = 0;
    string phase = "reset";
    exp_t  q0[$], q1[$];

    int          left[2], drain[2];
    bit          halted[2];
    logic [31:0] msc[2], mfc[2];

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl u0 (
        .CLK(CLK), .Reset(Reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .Branch(Branch), .Jump(Jump), .Halt(Halt),
        .PCWre(o0[6]), .IF_ID_Wre(o0[5]), .ControlSrc(o0[4]), .IF_ID_Flush(o0[3]),
        .ID_EX_Flush(o0[2]), .EX_MEM_Flush(o0[1]), .Halted(o0[0])
`ifdef HAZARD_PERF_CNT_EN
        , .StallCnt(sc0), .FlushCnt(fc0)
`endif
    );

    pipeline_hazard_ctrl #(.STALL_CYCLES(3)) u3 (
        .CLK(CLK), .Reset(Reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .Branch(Branch), .Jump(Jump), .Halt(Halt),
        .PCWre(o1[6]), .IF_ID_Wre(o1[5]), .ControlSrc(o1[4]), .IF_ID_Flush(o1[3]),
        .ID_EX_Flush(o1[2]), .EX_MEM_Flush(o1[1]), .Halted(o1[0])
`ifdef HAZARD_PERF_CNT_EN
        , .StallCnt(sc1), .FlushCnt(fc1)
`endif
    );

    // Reference: remaining bubbles / drain cycles as plain counts.
    // Output bits {PCWre, IF_ID_Wre, ControlSrc, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Halted}
    task automatic model_step(input int k, output exp_t e);
        logic lu;
        lu = EX_MemRead && EX_rt != 0 && (EX_rt == ID_rs || (ID_UsesRt && EX_rt == ID_rt));
        e.sc = msc[k];
        e.fc = mfc[k];
        if (!Reset) begin
            e.o = 7'b0001110;
            left[k] = 0; drain[k] = 0; halted[k] = 0; msc[k] = 0; mfc[k] = 0;
        end else if (halted[k]) begin
            e.o = 7'b0000001;
        end else if (Branch) begin
            e.o = 7'b1101110;
            left[k] = 0; drain[k] = 0; mfc[k] = mfc[k] + 1;
        end else if (drain[k] > 0) begin
            e.o = 7'b0101000;
            drain[k] = drain[k] - 1;
            if (drain[k] == 0) halted[k] = 1;
        end else if (left[k] > 0 || lu) begin
            e.o = 7'b0010000;
            left[k] = (left[k] > 0) ? left[k] - 1 : (k ? 3 : 1) - 1;
            msc[k] = msc[k] + 1;
        end else if (Jump) begin
            e.o = 7'b1101000;
            mfc[k] = mfc[k] + 1;
        end else if (Halt) begin
            e.o = 7'b0101000;
            drain[k] = DRAIN;
        end else begin
            e.o = 7'b1100000;
        end
    endtask

    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ut, input logic mr, input logic [4:0] ert,
                        input logic br, input logic j, input logic h);
        exp_t e;
        Reset = rst; ID_rs = rs; ID_rt = rt; ID_UsesRt = ut;
        EX_MemRead = mr; EX_rt = ert; Branch = br; Jump = j; Halt = h;
        model_step(0, e); q0.push_back(e);
        model_step(1, e); q1.push_back(e);
        @(posedge CLK);
        #2;
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 2, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s phase=%s cycle=%0d got=%h expected=%h", nm, phase, cycle, got, exp);
        end
    endtask

    // Monitor: compare whatever the DUTs present against the queued expectations
    always @(negedge CLK) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("u0_outputs", {25'd0, o0}, {25'd0, e.o});
`ifdef HAZARD_PERF_CNT_EN
            chk("u0_StallCnt", sc0, e.sc);
            chk("u0_FlushCnt", fc0, e.fc);
`endif
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("u3_outputs", {25'd0, o1}, {25'd0, e.o});
`ifdef HAZARD_PERF_CNT_EN
            chk("u3_StallCnt", sc1, e.sc);
            chk("u3_FlushCnt", fc1, e.fc);
`endif
        end
    end

    initial begin
        @(posedge CLK);
        #2;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        phase = "loaduse_rs";
        idle(1);
        step(1, 8, 2, 0, 1, 8, 0, 0, 0);
        idle(4);
        phase = "no_stall_cases";
        step(1, 0, 2, 0, 1, 0, 0, 0, 0);
        step(1, 1, 5, 0, 1, 5, 0, 0, 0);
        idle(1);
        step(1, 1, 5, 1, 1, 5, 0, 0, 0);
        idle(4);
        phase = "branch_over_lu";
        step(1, 8, 2, 0, 1, 8, 1, 0, 0);
        idle(2);
        phase = "jump_held_in_stall";
        step(1, 8, 2, 0, 1, 8, 0, 1, 0);
        step(1, 8, 2, 0, 0, 8, 0, 1, 0);
        step(1, 8, 2, 0, 0, 8, 0, 1, 0);
        step(1, 8, 2, 0, 0, 8, 0, 1, 0);
        idle(2);
        phase = "halt_drain";
        step(1, 1, 2, 0, 0, 0, 0, 0, 1);
        idle(6);
        phase = "branch_ignored_halted";
        step(1, 1, 2, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        phase = "branch_in_drain";
        step(1, 1, 2, 0, 0, 0, 0, 0, 1);
        idle(1);
        step(1, 1, 2, 0, 0, 0, 1, 0, 0);
        idle(5);
        phase = "reset_mid_stall";
        step(1, 8, 2, 0, 1, 8, 0, 0, 0);
        step(0, 8, 2, 0, 1, 8, 0, 0, 0);
        idle(4);
        phase = "random";
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 59) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
        phase = "end";
        idle(1);
        @(negedge CLK);
        #1;
        chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
